// File: rtl/running_avg_pkg.sv
// Shared definitions for the running_avg boxcar averager: FSM states,
// default configuration and derived widths.
package running_avg_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH,
    ST_FILL,
    ST_RUN
  } state_t;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_LOG2_WIN = 3;

  function automatic int unsigned win_len(input int unsigned log2_win);
    return 32'd1 << log2_win;
  endfunction

  localparam int unsigned WIN   = 32'd1 << DEF_LOG2_WIN;
  localparam int unsigned SUM_W = DEF_DATA_W + DEF_LOG2_WIN;

endpackage

// File: rtl/running_avg_if.sv
// Sample-in / average-out handshake bundle for running_avg, plus the flush request
// and the status strobes consumed by the downstream averages counter.
interface running_avg_if #(
  parameter int unsigned DATA_W = running_avg_pkg::DEF_DATA_W
);
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_avg;
  logic              out_ready;
  logic              avg_done;
  logic              window_full;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_avg, avg_done, window_full
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_avg, avg_done, window_full
  );
endinterface

// File: rtl/avg_window_buf.sv
// Circular sample store for the averaging window: asynchronous read of the
// oldest slot, synchronous write, no reset (contents are flushed by the owner).
module avg_window_buf #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [(1 << ADDR_W)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/running_avg.sv
// Boxcar running average over the last 2^LOG2_WIN samples: running sum plus
// circular buffer, registered average on a ready/valid output with avg_done strobe.
module running_avg
  import running_avg_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned LOG2_WIN = DEF_LOG2_WIN
) (
  input logic          clk,
  input logic          rst,
  running_avg_if.slave bus
);
  localparam int unsigned DEPTH  = win_len(LOG2_WIN);
  localparam int unsigned ACC_W  = DATA_W + LOG2_WIN;
  localparam int unsigned FILL_W = LOG2_WIN + 1;

  state_t              state;
  state_t              state_nxt;
  logic [LOG2_WIN-1:0] wr_ptr;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    next_sum;
  logic [FILL_W-1:0]   fill;
  logic [FILL_W-1:0]   fill_nxt;
  logic [DATA_W-1:0]   oldest;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   out_avg_q;
  logic                out_valid_q;
  logic                in_ready;
  logic                accept;
  logic                flushing;
  logic                last_slot;
  logic                fills_window;
  logic                buf_we;

  assign flushing  = (state == ST_FLUSH);
  assign last_slot = (wr_ptr == LOG2_WIN'(DEPTH - 1));

  // clear blocks the accept in its own cycle so nothing lands in a window being discarded
  assign in_ready = !flushing && !bus.clear && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Slot at wr_ptr is the oldest sample; it was zeroed by the flush while filling
  assign next_sum     = sum + ACC_W'(bus.in_data) - ACC_W'(oldest);
  assign fill_nxt     = (fill == FILL_W'(DEPTH)) ? fill : fill + FILL_W'(1);
  assign fills_window = accept && (fill_nxt == FILL_W'(DEPTH));

  assign buf_we  = (flushing && !bus.clear) || accept;
  assign wr_data = flushing ? '0 : bus.in_data;

  avg_window_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (LOG2_WIN)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_addr (wr_ptr),
    .rd_data (oldest)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FLUSH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = ST_FLUSH;
    end else begin
      unique case (state)
        ST_FLUSH: if (last_slot) state_nxt = ST_FILL;
        ST_FILL:  if (fills_window) state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_RUN;
        default:  state_nxt = ST_FLUSH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      sum         <= '0;
      fill        <= '0;
      out_valid_q <= 1'b0;
      out_avg_q   <= '0;
    end else if (bus.clear) begin
      wr_ptr      <= '0;
      sum         <= '0;
      fill        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (flushing) begin
        wr_ptr <= wr_ptr + LOG2_WIN'(1);
      end else if (accept) begin
        wr_ptr <= wr_ptr + LOG2_WIN'(1);
        sum    <= next_sum;
        fill   <= fill_nxt;
      end
      // A fresh average takes priority over retiring the one just consumed
      if (fills_window) begin
        out_valid_q <= 1'b1;
        out_avg_q   <= next_sum[ACC_W-1:LOG2_WIN];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_avg     = out_avg_q;
  assign bus.avg_done    = out_valid_q && bus.out_ready && !bus.clear;
  assign bus.window_full = (fill == FILL_W'(DEPTH));

  a_done_needs_valid : assert property (
    @(posedge clk) disable iff (rst) bus.avg_done |-> out_valid_q);

  a_output_held : assert property (
    @(posedge clk) disable iff (rst)
    (out_valid_q && !bus.out_ready && !bus.clear) |=> (out_valid_q && $stable(out_avg_q)));

endmodule

// File: tb/tb_running_avg.sv
// Self-checking bench for running_avg (DATA_W=8, LOG2_WIN=2): directed scenarios
// and randomized traffic checked against a queue-based window model.
module tb_running_avg;
  import running_avg_pkg::*;

  localparam int unsigned DW   = 8;
  localparam int unsigned LW   = 2;
  localparam int          NWIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  running_avg_if #(.DATA_W(DW)) bus ();

  running_avg #(
    .DATA_W   (DW),
    .LOG2_WIN (LW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int win_q[$];

  function automatic void model_flush();
    win_q.delete();
  endfunction

  // Window since last flush; an average exists once NWIN samples are held
  function automatic bit model_accept(input int x, output int avg);
    int s = 0;
    win_q.push_back(x);
    if (win_q.size() > NWIN) void'(win_q.pop_front());
    foreach (win_q[i]) s += win_q[i];
    avg = s / NWIN;
    return (win_q.size() == NWIN);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int x, output bit ok);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(x);
    #1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    ok = bus.in_ready;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_flush(output bit ok);
    int n = 0;
    bus.clear    = 1'b1;
    bus.in_valid = 1'b0;
    tick();
    bus.clear = 1'b0;
    #1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    ok = bus.in_ready;
    model_flush();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_avg !== 8'd0) begin bad++; $display("FAIL rst_out_avg: got %0d want 0", bus.out_avg); end
    total++; if (bus.avg_done !== 1'b0) begin bad++; $display("FAIL rst_avg_done: got %b want 0", bus.avg_done); end
    total++; if (bus.window_full !== 1'b0) begin bad++; $display("FAIL rst_window_full: got %b want 0", bus.window_full); end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (bus.in_ready !== (k >= NWIN)) begin bad++; $display("FAIL flush_in_ready cycle %0d: got %b want %b", k, bus.in_ready, (k >= NWIN)); end
      total++; if (bus.out_valid !== 1'b0 || bus.avg_done !== 1'b0) begin bad++; $display("FAIL flush_outputs cycle %0d: got valid=%b done=%b want 0 0", k, bus.out_valid, bus.avg_done); end
    end
    model_flush();
  endtask

  task automatic test_fill_slide();
    int vals[5] = '{10, 20, 30, 40, 50};
    int exp;
    bit has, ok;
    for (int i = 0; i < 5; i++) begin
      push(vals[i], ok);
      total++; if (!ok) begin bad++; $display("FAIL fill_accept_timeout sample %0d: got no in_ready want in_ready", i); end
      has = model_accept(vals[i], exp);
      total++; if (bus.out_valid !== has) begin bad++; $display("FAIL fill_out_valid sample %0d: got %b want %b", i, bus.out_valid, has); end
      total++; if (bus.window_full !== (i >= 3)) begin bad++; $display("FAIL fill_window_full sample %0d: got %b want %b", i, bus.window_full, (i >= 3)); end
      if (has) begin
        total++; if (bus.out_avg !== DW'(exp)) begin bad++; $display("FAIL fill_out_avg sample %0d: got %0d want %0d", i, bus.out_avg, exp); end
        total++; if (bus.avg_done !== 1'b1) begin bad++; $display("FAIL fill_avg_done sample %0d: got %b want 1", i, bus.avg_done); end
      end
      if (i == 3) begin
        tick();
        total++; if (bus.avg_done !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL fill_done_one_cycle: got done=%b valid=%b want 0 0", bus.avg_done, bus.out_valid); end
      end
    end
    tick();
  endtask

  task automatic test_trunc_max();
    int vals[9] = '{1, 1, 1, 2, 255, 255, 255, 255, 0};
    int exp;
    bit has, ok;
    do_flush(ok);
    total++; if (!ok) begin bad++; $display("FAIL trunc_flush_timeout: got no in_ready want in_ready"); end
    for (int i = 0; i < 9; i++) begin
      push(vals[i], ok);
      has = model_accept(vals[i], exp);
      total++; if (bus.out_valid !== has) begin bad++; $display("FAIL trunc_out_valid sample %0d: got %b want %b", i, bus.out_valid, has); end
      if (has) begin
        total++; if (bus.out_avg !== DW'(exp)) begin bad++; $display("FAIL trunc_out_avg sample %0d: got %0d want %0d", i, bus.out_avg, exp); end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int exp, held;
    bit has, ok;
    bus.out_ready = 1'b0;
    push(100, ok);
    has = model_accept(100, held);
    total++; if (bus.out_valid !== has || bus.out_avg !== DW'(held)) begin bad++; $display("FAIL bp_first: got valid=%b avg=%0d want valid=%b avg=%0d", bus.out_valid, bus.out_avg, has, held); end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready stall %0d: got %b want 0", i, bus.in_ready); end
      total++; if (bus.avg_done !== 1'b0) begin bad++; $display("FAIL bp_avg_done stall %0d: got %b want 0", i, bus.avg_done); end
      total++; if (bus.out_valid !== 1'b1 || bus.out_avg !== DW'(held)) begin bad++; $display("FAIL bp_hold stall %0d: got valid=%b avg=%0d want valid=1 avg=%0d", i, bus.out_valid, bus.out_avg, held); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.avg_done !== 1'b1 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got done=%b ready=%b want 1 1", bus.avg_done, bus.in_ready); end
    tick();
    has = model_accept(77, exp);
    total++; if (bus.out_valid !== has || bus.out_avg !== DW'(exp)) begin bad++; $display("FAIL bp_next: got valid=%b avg=%0d want valid=%b avg=%0d", bus.out_valid, bus.out_avg, has, exp); end
    bus.in_valid = 1'b0;
    tick();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got valid=%b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    int exp, s;
    int pulses = 0;
    for (int i = 0; i < 8; i++) begin
      s = int'($urandom_range(0, 255));
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(s);
      void'(model_accept(s, exp));
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready beat %0d: got %b want 1", i, bus.in_ready); end
      tick();
      total++; if (bus.out_valid !== 1'b1 || bus.out_avg !== DW'(exp)) begin bad++; $display("FAIL b2b_avg beat %0d: got valid=%b avg=%0d want valid=1 avg=%0d", i, bus.out_valid, bus.out_avg, exp); end
      if (bus.avg_done === 1'b1) pulses++;
    end
    bus.in_valid = 1'b0;
    total++; if (pulses != 8) begin bad++; $display("FAIL b2b_pulses: got %0d want 8", pulses); end
    tick();
    total++; if (bus.out_valid !== 1'b0 || bus.avg_done !== 1'b0) begin bad++; $display("FAIL b2b_drain: got valid=%b done=%b want 0 0", bus.out_valid, bus.avg_done); end
  endtask

  task automatic test_random();
    int exp_q[$];
    int a, s;
    bit has, acc, ready_m;
    for (int c = 0; c < 300; c++) begin
      s = int'($urandom_range(0, 255));
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_data   = DW'(s);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ready_m = (exp_q.size() == 0) || bus.out_ready;
      total++; if (bus.out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_out_valid cycle %0d: got %b want %b", c, bus.out_valid, (exp_q.size() != 0)); end
      total++; if (bus.in_ready !== ready_m) begin bad++; $display("FAIL rnd_in_ready cycle %0d: got %b want %b", c, bus.in_ready, ready_m); end
      total++; if (bus.avg_done !== ((exp_q.size() != 0) && bus.out_ready)) begin bad++; $display("FAIL rnd_avg_done cycle %0d: got %b want %b", c, bus.avg_done, ((exp_q.size() != 0) && bus.out_ready)); end
      if (exp_q.size() != 0 && bus.out_ready) begin
        total++; if (bus.out_avg !== DW'(exp_q[0])) begin bad++; $display("FAIL rnd_out_avg cycle %0d: got %0d want %0d", c, bus.out_avg, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      acc = bus.in_valid && ready_m;
      if (acc) begin
        has = model_accept(s, a);
        if (has) exp_q.push_back(a);
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_clear();
    int exp, s;
    bit has, ok;
    // clear in RUN with a sample offered and the output free
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd9;
    bus.clear     = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready: got %b want 0", bus.in_ready); end
    tick();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.window_full !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL clr_state: got full=%b valid=%b want 0 0", bus.window_full, bus.out_valid); end
    for (int k = 1; k <= NWIN; k++) begin
      tick();
      total++; if (bus.in_ready !== (k == NWIN)) begin bad++; $display("FAIL clr_flush_len cycle %0d: got %b want %b", k, bus.in_ready, (k == NWIN)); end
    end
    model_flush();
    for (int i = 0; i < NWIN; i++) begin
      s = int'($urandom_range(100, 255));
      push(s, ok);
      void'(model_accept(s, exp));
    end
    tick();
    // clear with an average pending and the consumer stalled
    bus.out_ready = 1'b0;
    push(250, ok);
    has = model_accept(250, exp);
    total++; if (bus.out_valid !== has) begin bad++; $display("FAIL clr_pending: got valid=%b want %b", bus.out_valid, has); end
    bus.clear = 1'b1;
    #1;
    total++; if (bus.avg_done !== 1'b0) begin bad++; $display("FAIL clr_no_done: got %b want 0", bus.avg_done); end
    tick();
    bus.clear = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.avg_done !== 1'b0) begin bad++; $display("FAIL clr_discard: got valid=%b done=%b want 0 0", bus.out_valid, bus.avg_done); end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= NWIN; k++) begin
      tick();
      total++; if (bus.in_ready !== (k == NWIN)) begin bad++; $display("FAIL clr2_flush_len cycle %0d: got %b want %b", k, bus.in_ready, (k == NWIN)); end
    end
    model_flush();
    for (int i = 0; i < NWIN; i++) begin
      push(4, ok);
      has = model_accept(4, exp);
    end
    total++; if (bus.out_valid !== 1'b1 || bus.out_avg !== 8'd4) begin bad++; $display("FAIL clr_refill: got valid=%b avg=%0d want valid=1 avg=4", bus.out_valid, bus.out_avg); end
    total++; if (bus.out_avg !== DW'(exp) || !has) begin bad++; $display("FAIL clr_refill_model: got %0d want %0d", bus.out_avg, exp); end
    tick();
  endtask

  task automatic test_async_rst();
    int exp;
    bit has, ok;
    bus.out_ready = 1'b0;
    push(200, ok);
    has = model_accept(200, exp);
    total++; if (bus.out_valid !== has || bus.out_avg !== DW'(exp)) begin bad++; $display("FAIL arst_pre: got valid=%b avg=%0d want valid=%b avg=%0d", bus.out_valid, bus.out_avg, has, exp); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_avg !== 8'd0) begin bad++; $display("FAIL arst_out: got valid=%b avg=%0d want 0 0", bus.out_valid, bus.out_avg); end
    total++; if (bus.window_full !== 1'b0 || bus.in_ready !== 1'b0 || bus.avg_done !== 1'b0) begin bad++; $display("FAIL arst_status: got full=%b ready=%b done=%b want 0 0 0", bus.window_full, bus.in_ready, bus.avg_done); end
    tick();
    rst = 1'b0;
    model_flush();
  endtask

  initial begin
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    $display("running_avg bench: package defaults WIN=%0d SUM_W=%0d, bench window %0d", WIN, SUM_W, NWIN);
    test_reset();
    test_fill_slide();
    test_trunc_max();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_clear();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want completion before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
